// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snake_pkg
// Brief    : Shared encodings, grid geometry and LFSR step for the snake game.
// Revision : 1.0 - initial release
// ============================================================================
package snake_pkg;

  localparam logic [1:0] RUNNING = 2'b00;
  localparam logic [1:0] DIE     = 2'b01;
  localparam logic [1:0] INITIAL = 2'b10;

  localparam logic [1:0] UP    = 2'b00;
  localparam logic [1:0] DOWN  = 2'b01;
  localparam logic [1:0] RIGHT = 2'b10;
  localparam logic [1:0] LEFT  = 2'b11;

  localparam int GRID_W  = 32;
  localparam int GRID_H  = 24;
  localparam int MAX_LEN = 64;
  localparam int COORD_W = 5;
  localparam int LFSR_W  = 10;

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_PLACE0 = 2'd1,
    S_RUN    = 2'd2,
    S_DIE    = 2'd3
  } ctrl_state_t;

  typedef enum logic [1:0] {
    P_IDLE  = 2'd0,
    P_CHECK = 2'd1,
    P_SCAN  = 2'd2
  } placer_state_t;

  // x^10 + x^7 + 1, Fibonacci form, shifting left
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], v[9] ^ v[6]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/snake_game_ctrl_food_placer.sv
`default_nettype none
// ============================================================================
// Module   : food_placer
// Brief    : Draws food candidates from an LFSR and rejects off-grid or body cells.
// Revision : 1.0 - initial release
// ============================================================================
module food_placer
  import snake_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED = 10'h2A5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_req,
  input  logic                       seed_load,
  input  logic [5:0]                 snake_length,
  input  logic [MAX_LEN*COORD_W-1:0] snake_x_1dim,
  input  logic [MAX_LEN*COORD_W-1:0] snake_y_1dim,
  output logic                       busy,
  output logic                       done,
  output logic [COORD_W-1:0]         cand_x,
  output logic [COORD_W-1:0]         cand_y
);

  placer_state_t     state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [5:0]        idx_q, idx_d;
  logic [5:0]        len_q, len_d;

  logic [COORD_W-1:0] seg_x;
  logic [COORD_W-1:0] seg_y;
  logic               seg_hit;
  logic               last_seg;
  logic               y_bad;

  assign cand_x   = lfsr_q[COORD_W-1:0];
  assign cand_y   = lfsr_q[2*COORD_W-1:COORD_W];
  assign seg_x    = snake_x_1dim[int'(idx_q) * COORD_W +: COORD_W];
  assign seg_y    = snake_y_1dim[int'(idx_q) * COORD_W +: COORD_W];
  assign seg_hit  = (seg_x == cand_x) && (seg_y == cand_y);
  assign last_seg = ({1'b0, idx_q} + 7'd1) >= {1'b0, len_q};
  assign y_bad    = cand_y > COORD_W'(GRID_H - 1);
  assign busy     = (state_q != P_IDLE);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    len_d   = len_q;
    done    = 1'b0;
    if (seed_load) begin
      // Reload also aborts any attempt left over from a previous game
      lfsr_d  = LFSR_SEED;
      idx_d   = '0;
      state_d = start_req ? P_CHECK : P_IDLE;
    end else begin
      unique case (state_q)
        P_IDLE: begin
          if (start_req) state_d = P_CHECK;
        end
        P_CHECK: begin
          len_d = snake_length;
          idx_d = '0;
          if (y_bad) lfsr_d = lfsr_next(lfsr_q);
          else       state_d = P_SCAN;
        end
        P_SCAN: begin
          if (seg_hit) begin
            lfsr_d  = lfsr_next(lfsr_q);
            state_d = P_CHECK;
          end else if (last_seg) begin
            lfsr_d  = lfsr_next(lfsr_q);
            done    = 1'b1;
            state_d = P_IDLE;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
        default: state_d = P_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= P_IDLE;
      lfsr_q  <= LFSR_SEED;
      idx_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/snake_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : snake_game_ctrl
// Brief    : Game FSM, move-tick generation, food placement sequencing and score.
// Revision : 1.0 - initial release
// ============================================================================
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned       TICK_CYCLES = 50_000_000,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 10'h2A5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       pause,
  input  logic                       slow,
  input  logic                       hit_boundary,
  input  logic                       hit_self,
  input  logic                       get_food,
  input  logic [5:0]                 snake_length,
  input  logic [MAX_LEN*COORD_W-1:0] snake_x_1dim,
  input  logic [MAX_LEN*COORD_W-1:0] snake_y_1dim,
  output logic [1:0]                 game_state,
  output logic                       move_tick,
  output logic [COORD_W-1:0]         food_x,
  output logic [COORD_W-1:0]         food_y,
  output logic                       food_valid,
  output logic [7:0]                 score
);

  localparam int unsigned      CNT_W     = $clog2(2 * TICK_CYCLES);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(TICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(2 * TICK_CYCLES - 1);

  ctrl_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         score_q, score_d;
  logic [COORD_W-1:0] food_x_q, food_x_d;
  logic [COORD_W-1:0] food_y_q, food_y_d;
  logic               food_valid_q, food_valid_d;
  logic               get_food_q, get_food_d;

  logic               start_req;
  logic               seed_load;
  logic               placer_busy;
  logic               placer_done;
  logic [COORD_W-1:0] cand_x;
  logic [COORD_W-1:0] cand_y;

  logic               hit;
  logic               food_rise;
  logic [CNT_W-1:0]   period_last;
  logic               at_last;

  food_placer #(
    .LFSR_SEED (LFSR_SEED)
  ) u_placer (
    .clk          (clk),
    .rst          (rst),
    .start_req    (start_req),
    .seed_load    (seed_load),
    .snake_length (snake_length),
    .snake_x_1dim (snake_x_1dim),
    .snake_y_1dim (snake_y_1dim),
    .busy         (placer_busy),
    .done         (placer_done),
    .cand_x       (cand_x),
    .cand_y       (cand_y)
  );

  assign hit         = hit_boundary | hit_self;
  assign food_rise   = get_food & ~get_food_q;
  assign period_last = slow ? SLOW_LAST : FAST_LAST;
  // >= rather than == so a slow->fast switch past the short period still wraps at once
  assign at_last     = cnt_q >= period_last;

  assign food_x     = food_x_q;
  assign food_y     = food_y_q;
  assign food_valid = food_valid_q;
  assign score      = score_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    score_d      = score_q;
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    food_valid_d = food_valid_q;
    get_food_d   = get_food;
    start_req    = 1'b0;
    seed_load    = 1'b0;
    move_tick    = 1'b0;
    game_state   = INITIAL;
    unique case (state_q)
      S_INIT: begin
        score_d      = '0;
        food_valid_d = 1'b0;
        cnt_d        = '0;
        seed_load    = 1'b1;
        if (start) begin
          start_req = 1'b1;
          state_d   = S_PLACE0;
        end
      end
      S_PLACE0: begin
        if (placer_done) begin
          food_x_d     = cand_x;
          food_y_d     = cand_y;
          food_valid_d = 1'b1;
          cnt_d        = '0;
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        game_state = RUNNING;
        if (hit) begin
          state_d = S_DIE;
        end else if (placer_done) begin
          food_x_d     = cand_x;
          food_y_d     = cand_y;
          food_valid_d = 1'b1;
        end else if (food_rise && food_valid_q && !placer_busy) begin
          // Eating freezes the tick counter until the new food is latched
          score_d      = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          food_valid_d = 1'b0;
          start_req    = 1'b1;
        end else if (food_valid_q && !pause) begin
          if (at_last) begin
            cnt_d     = '0;
            move_tick = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DIE: begin
        game_state = DIE;
        if (start) begin
          score_d      = '0;
          food_valid_d = 1'b0;
          state_d      = S_INIT;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_INIT;
      cnt_q        <= '0;
      score_q      <= '0;
      food_x_q     <= '0;
      food_y_q     <= '0;
      food_valid_q <= 1'b0;
      get_food_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      score_q      <= score_d;
      food_x_q     <= food_x_d;
      food_y_q     <= food_y_d;
      food_valid_q <= food_valid_d;
      get_food_q   <= get_food_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snake_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_game_ctrl
// Brief    : Directed and random stimulus against a cycle-level game model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snake_game_ctrl;

  localparam int TICK = 4;
  localparam int SEED = 'h2A5;
  localparam int PH_IDLE  = 0;
  localparam int PH_PLACE = 1;
  localparam int PH_PLAY  = 2;
  localparam int PH_DEAD  = 3;

  logic         clk = 1'b0;
  logic         rst, start, pause, slow, hit_boundary, hit_self, get_food;
  logic [5:0]   snake_length;
  logic [319:0] snake_x_1dim, snake_y_1dim;
  logic [1:0]   game_state;
  logic         move_tick;
  logic [4:0]   food_x, food_y;
  logic         food_valid;
  logic [7:0]   score;

  always #5 clk = ~clk;

  snake_game_ctrl #(
    .TICK_CYCLES (TICK),
    .LFSR_SEED   (10'h2A5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .pause        (pause),
    .slow         (slow),
    .hit_boundary (hit_boundary),
    .hit_self     (hit_self),
    .get_food     (get_food),
    .snake_length (snake_length),
    .snake_x_1dim (snake_x_1dim),
    .snake_y_1dim (snake_y_1dim),
    .game_state   (game_state),
    .move_tick    (move_tick),
    .food_x       (food_x),
    .food_y       (food_y),
    .food_valid   (food_valid),
    .score        (score)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // emulated snake core body
  int bx[64], by[64];
  int blen;
  int ix[64], iy[64];
  int ilen;
  int dir;
  bit grow;

  // behavioural game model
  int m_phase, m_score, m_fx, m_fy, m_lfsr, m_cnt, m_left, m_nfx, m_nfy, m_nlfsr;
  bit m_fv, m_gf_prev;
  int ticks_seen;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lfsr_step(input int l);
    return ((l << 1) & 'h3FF) | (((l >> 9) ^ (l >> 6)) & 1);
  endfunction

  // Attempts until a free on-grid cell; returns total cycles, the cell and the LFSR after
  task automatic plan(input int l0, output int cyc, output int fx, output int fy, output int lend);
    int  l;
    bit  ok;
    l = l0; ok = 0; cyc = 0; fx = 0; fy = 0;
    for (int a = 0; a < 4096 && !ok; a++) begin
      int x, y;
      x = l % 32;
      y = l / 32;
      cyc++;
      if (y < 24) begin
        ok = 1;
        for (int i = 0; i < blen && ok; i++) begin
          cyc++;
          if (bx[i] == x && by[i] == y) ok = 0;
        end
      end
      if (ok) begin fx = x; fy = y; end
      l = lfsr_step(l);
    end
    lend = l;
  endtask

  task automatic reset_body();
    for (int i = 0; i < 64; i++) begin
      bx[i] = (i < ilen) ? ix[i] : 0;
      by[i] = (i < ilen) ? iy[i] : 0;
    end
    blen = ilen;
    grow = 0;
  endtask

  task automatic drive_body();
    snake_length = 6'(blen);
    for (int i = 0; i < 64; i++) begin
      snake_x_1dim[i*5 +: 5] = 5'(bx[i]);
      snake_y_1dim[i*5 +: 5] = 5'(by[i]);
    end
  endtask

  task automatic core_move();
    if (grow && blen < 20) blen++;
    grow = 0;
    for (int i = 63; i > 0; i--) begin
      bx[i] = bx[i-1];
      by[i] = by[i-1];
    end
    case (dir)
      0:       by[0] = (by[0] + 23) % 24;
      1:       by[0] = (by[0] + 1) % 24;
      2:       bx[0] = (bx[0] + 1) % 32;
      default: bx[0] = (bx[0] + 31) % 32;
    endcase
  endtask

  task automatic model_reset();
    m_phase = PH_IDLE; m_score = 0; m_fx = 0; m_fy = 0; m_fv = 0;
    m_lfsr = SEED; m_cnt = 0; m_left = 0; m_gf_prev = 0;
  endtask

  task automatic latch_food();
    int overlap;
    overlap = 0;
    m_fx = m_nfx; m_fy = m_nfy; m_fv = 1; m_lfsr = m_nlfsr;
    for (int i = 0; i < blen; i++)
      if (bx[i] == m_fx && by[i] == m_fy) overlap = 1;
    chk("food_on_body", overlap, 0);
  endtask

  // One clock cycle: inputs already set by the caller, check, advance model
  task automatic step();
    int  exp_gs, c;
    bit  hit, rise, tick;
    drive_body();
    #2;
    hit    = hit_boundary | hit_self;
    rise   = get_food && !m_gf_prev;
    exp_gs = (m_phase == PH_PLAY) ? 0 : (m_phase == PH_DEAD) ? 1 : 2;
    tick   = (m_phase == PH_PLAY) && !hit && !(rise && m_fv) && m_fv && !pause &&
             (m_cnt >= (slow ? 2*TICK : TICK) - 1);
    chk("game_state", int'(game_state), exp_gs);
    chk("move_tick",  int'(move_tick),  int'(tick));
    chk("food_x",     int'(food_x),     m_fx);
    chk("food_y",     int'(food_y),     m_fy);
    chk("food_valid", int'(food_valid), int'(m_fv));
    chk("score",      int'(score),      m_score);
    if (move_tick === 1'b1) ticks_seen++;
    if (rst) begin
      model_reset();
    end else begin
      case (m_phase)
        PH_IDLE: begin
          m_score = 0; m_fv = 0; m_lfsr = SEED; m_cnt = 0;
          if (start) begin
            plan(SEED, c, m_nfx, m_nfy, m_nlfsr);
            m_left  = c;
            m_phase = PH_PLACE;
          end
        end
        PH_PLACE: begin
          m_left--;
          if (m_left == 0) begin
            latch_food();
            m_cnt   = 0;
            m_phase = PH_PLAY;
          end
        end
        PH_PLAY: begin
          if (hit) begin
            m_phase = PH_DEAD;
            m_left  = 0;
          end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) latch_food();
          end else if (rise && m_fv) begin
            if (m_score < 255) m_score++;
            m_fv = 0;
            plan(m_lfsr, c, m_nfx, m_nfy, m_nlfsr);
            m_left = c;
            grow   = 1;
          end else if (m_fv && !pause) begin
            m_cnt = tick ? 0 : m_cnt + 1;
          end
        end
        default: begin
          if (start) begin
            m_phase = PH_IDLE; m_score = 0; m_fv = 0;
          end
        end
      endcase
      m_gf_prev = get_food;
    end
    if (tick) core_move();
    if (m_phase == PH_IDLE) reset_body();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (food_valid !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    chk(name, int'(food_valid === 1'b1), 1);
  endtask

  initial begin
    int n, gf_hold;
    rst = 1; start = 0; pause = 0; slow = 0;
    hit_boundary = 0; hit_self = 0; get_food = 0; dir = 2;
    ilen = 3;
    ix[0] = 15; iy[0] = 9;
    ix[1] = 15; iy[1] = 10;
    ix[2] = 15; iy[2] = 11;
    reset_body();
    drive_body();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    step();
    rst = 0;
    chk("rst_state", int'(game_state), 2);
    chk("rst_valid", int'(food_valid), 0);
    chk("rst_score", int'(score), 0);

    // first placement and tick cadence
    start = 1; step(); start = 0;
    repeat (3) step();
    chk("place_latency_lo", int'(food_valid), 0);
    step();
    chk("place_latency_hi", int'(food_valid), 1);
    chk("first_food_x", int'(food_x), 5);
    chk("first_food_y", int'(food_y), 21);
    chk("run_state", int'(game_state), 0);
    ticks_seen = 0; repeat (12) step();
    chk("ticks_fast", ticks_seen, 3);
    slow = 1; ticks_seen = 0; repeat (16) step();
    chk("ticks_slow", ticks_seen, 2);

    // pause holds the counter mid-period
    slow = 0; repeat (2) step();
    pause = 1; ticks_seen = 0; repeat (10) step();
    chk("ticks_paused", ticks_seen, 0);
    pause = 0; ticks_seen = 0; step();
    chk("resume_no_extra", ticks_seen, 0);
    step();
    chk("resume_held_count", ticks_seen, 1);

    // held get_food counts once, ticks frozen during re-placement
    get_food = 1; step();
    chk("eat_valid_low", int'(food_valid), 0);
    repeat (5) step();
    get_food = 0;
    chk("eat_score", int'(score), 1);
    ticks_seen = 0;
    wait_valid("eat_timeout", n);
    chk("eat_no_ticks", ticks_seen, 0);
    step();

    // hit beats simultaneous food edge
    hit_self = 1; get_food = 1; ticks_seen = 0; step();
    hit_self = 0; get_food = 0;
    chk("hit_no_tick", ticks_seen, 0);
    chk("die_state", int'(game_state), 1);
    chk("die_score", int'(score), 1);
    repeat (3) step();
    start = 1; step(); start = 0;
    chk("restart_state", int'(game_state), 2);
    chk("restart_score", int'(score), 0);

    // candidate on the body is rejected
    ix[1] = 5; iy[1] = 21;
    reset_body();
    start = 1; step(); start = 0;
    wait_valid("forced_timeout", n);
    chk("forced_latency", n, 7);
    chk("forced_x", int'(food_x), 11);
    chk("forced_y", int'(food_y), 10);

    // reset in the middle of a scan
    ix[1] = 15; iy[1] = 10;
    hit_boundary = 1; step(); hit_boundary = 0;
    start = 1; step(); start = 0;
    start = 1; step(); start = 0;
    repeat (2) step();
    rst = 1; step(); rst = 0;
    chk("midscan_rst_state", int'(game_state), 2);
    chk("midscan_rst_valid", int'(food_valid), 0);
    chk("midscan_rst_score", int'(score), 0);
    chk("midscan_rst_fx", int'(food_x), 0);
    chk("midscan_rst_fy", int'(food_y), 0);
    chk("midscan_rst_tick", int'(move_tick), 0);
    start = 1; step(); start = 0;
    wait_valid("replay_timeout", n);
    chk("replay_food_x", int'(food_x), 5);
    chk("replay_food_y", int'(food_y), 21);

    // random play
    gf_hold = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      start        = ($urandom_range(0, 39) == 0);
      pause        = pause ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 29) == 0);
      hit_self     = ($urandom_range(0, 249) == 0);
      hit_boundary = ($urandom_range(0, 249) == 0);
      rst          = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 63) == 0) slow = ~slow;
      if ($urandom_range(0, 7) == 0) dir = $urandom_range(0, 3);
      if (gf_hold > 0) begin
        get_food = 1;
        gf_hold--;
      end else if (get_food) begin
        get_food = 0;
      end else if ($urandom_range(0, 11) == 0) begin
        get_food = 1;
        gf_hold  = $urandom_range(0, 5);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
